// File: rtl/ram_bytewr_pipe.sv
// Single-port RAM with active-low byte-lane writes and write-through readback.
// Every accepted access returns one response after 1+PIPE cycles; no backpressure, requests are dropped while busy.
module ram_bytewr_pipe #(
  parameter int DW             = 32,
  parameter int AW             = 13,
  parameter int PIPE           = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            req,
  input  logic            rnw,
  input  logic [AW-1:0]   address,
  input  logic [DW/8-1:0] cs_b,
  input  logic [DW-1:0]   din,
  output logic [DW-1:0]   dout,
  output logic            dout_valid,
  output logic            busy
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_clr_cnt;
  logic [AW-1:0]   w_clr_cnt_nxt;
  logic [DW-1:0]   r_mem [DEPTH];

  logic            w_accept;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [DW-1:0]   w_old;
  logic [DW-1:0]   w_merged;
  logic [DW-1:0]   w_resp;
  logic [DW-1:0]   w_wdat;

  logic            r_s1_vld;
  logic [DW-1:0]   r_s1_dat;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state   <= RST_STATE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    busy          = 1'b0;
    case (r_state)
      S_CLEAR: begin
        busy          = 1'b1;
        w_clr_cnt_nxt = r_clr_cnt + AW'(1);
        if (&r_clr_cnt) w_state_nxt = S_RUN;
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = RST_STATE;
    endcase
  end

  assign w_accept = req && (r_state == S_RUN);
  assign w_old    = r_mem[address];

  // Unselected lanes keep the old byte, so the same word serves as write data and response.
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < NB; i++) begin
      if (!cs_b[i]) w_merged[8*i +: 8] = din[8*i +: 8];
    end
  end

  assign w_resp  = rnw ? w_old : w_merged;
  assign w_we    = (r_state == S_CLEAR) || (w_accept && !rnw);
  assign w_waddr = (r_state == S_CLEAR) ? r_clr_cnt : address;
  assign w_wdat  = (r_state == S_CLEAR) ? '0 : w_merged;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdat;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_s1_vld <= 1'b0;
      r_s1_dat <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) r_s1_dat <= w_resp;
    end
  end

  generate
    if (PIPE != 0) begin : g_pipe
      logic          r_s2_vld;
      logic [DW-1:0] r_s2_dat;

      always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
          r_s2_vld <= 1'b0;
          r_s2_dat <= '0;
        end else begin
          r_s2_vld <= r_s1_vld;
          if (r_s1_vld) r_s2_dat <= r_s1_dat;
        end
      end

      assign dout       = r_s2_dat;
      assign dout_valid = r_s2_vld;
    end else begin : g_nopipe
      assign dout       = r_s1_dat;
      assign dout_valid = r_s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_ram_bytewr_pipe.sv
// Bench for ram_bytewr_pipe: a PIPE=0 and a PIPE=1 instance (AW=4) share stimulus; a word model feeds per-instance response queues.
module tb_ram_bytewr_pipe;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        req = 1'b0;
  logic        rnw = 1'b1;
  logic [3:0]  address = '0;
  logic [3:0]  cs_b = '1;
  logic [31:0] din = '0;

  logic [31:0] d0_dout, d1_dout;
  logic        d0_vld, d1_vld, d0_busy, d1_busy;

  logic [31:0] model [16];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ram_bytewr_pipe #(.DW(32), .AW(4), .PIPE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .reset_b(reset_b), .req(req), .rnw(rnw), .address(address),
    .cs_b(cs_b), .din(din), .dout(d0_dout), .dout_valid(d0_vld), .busy(d0_busy));

  ram_bytewr_pipe #(.DW(32), .AW(4), .PIPE(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .reset_b(reset_b), .req(req), .rnw(rnw), .address(address),
    .cs_b(cs_b), .din(din), .dout(d1_dout), .dout_valid(d1_vld), .busy(d1_busy));

  // Response scoreboard: every dout_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_b) begin
      if (d0_vld) begin
        n_checks++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL p0_unexpected_resp: got dout=%h, required no response", d0_dout);
        end else begin
          logic [31:0] e0;
          e0 = q0.pop_front();
          if (d0_dout !== e0) begin
            n_fail++;
            $display("FAIL p0_resp_data: got %h, required %h", d0_dout, e0);
          end
        end
      end
      if (d1_vld) begin
        n_checks++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL p1_unexpected_resp: got dout=%h, required no response", d1_dout);
        end else begin
          logic [31:0] e1;
          e1 = q1.pop_front();
          if (d1_dout !== e1) begin
            n_fail++;
            $display("FAIL p1_resp_data: got %h, required %h", d1_dout, e1);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_expect(input logic w_rnw, input logic [3:0] a,
                             input logic [3:0] c, input logic [31:0] d);
    logic [31:0] e;
    e = model[a];
    if (!w_rnw) begin
      for (int i = 0; i < 4; i++) begin
        if (!c[i]) e[8*i +: 8] = d[8*i +: 8];
      end
      model[a] = e;
    end
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic drive(input logic r, input logic w_rnw, input logic [3:0] a,
                       input logic [3:0] c, input logic [31:0] d);
    @(negedge clk);
    req = r; rnw = w_rnw; address = a; cs_b = c; din = d;
    if (r) push_expect(w_rnw, a, c, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b1, 4'd0, 4'hF, 32'h0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  task automatic check_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (d0_busy !== 1'b1 || d1_busy !== 1'b1 || d0_vld !== 1'b0 || d1_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_sweep_cycle%0d: got busy=%b/%b valid=%b/%b, required busy=1/1 valid=0/0",
                 tag, i, d0_busy, d1_busy, d0_vld, d1_vld);
      end
    end
    @(negedge clk);
    n_checks++;
    if (d0_busy !== 1'b0 || d1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_sweep_end: got busy=%b/%b, required 0/0", tag, d0_busy, d1_busy);
    end
  endtask

  task automatic test_reset();
    reset_b = 1'b0; req = 1'b1; rnw = 1'b1; address = 4'd5; cs_b = 4'hF;
    clear_model();
    repeat (2) @(negedge clk);
    n_checks++;
    if (d0_dout !== 32'h0 || d1_dout !== 32'h0 || d0_vld !== 1'b0 || d1_vld !== 1'b0 ||
        d0_busy !== 1'b1 || d1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got dout=%h/%h valid=%b/%b busy=%b/%b, required 0/0 0/0 1/1",
               d0_dout, d1_dout, d0_vld, d1_vld, d0_busy, d1_busy);
    end
    @(negedge clk);
    reset_b = 1'b1;
    check_sweep("reset");
    // req was held high throughout; the first accepted read of addr 5 happens now
    push_expect(1'b1, 4'd5, 4'hF, 32'h0);
    drive(1'b0, 1'b1, 4'd0, 4'hF, 32'h0);
    n_checks++;
    if (d0_vld !== 1'b1 || d0_dout !== 32'h0) begin
      n_fail++;
      $display("FAIL clear_read_addr5: got valid=%b dout=%h, required 1 00000000", d0_vld, d0_dout);
    end
    idle(3);
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b0, 4'd3, 4'b0000, 32'hDEADBEEF);
    drive(1'b1, 1'b1, 4'd3, 4'b0000, 32'h0);
    n_checks++;
    if (d0_vld !== 1'b1 || d0_dout !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wr_resp_lat1: got valid=%b dout=%h, required 1 deadbeef", d0_vld, d0_dout);
    end
    drive(1'b0, 1'b1, 4'd0, 4'hF, 32'h0);
    n_checks++;
    if (d0_vld !== 1'b1 || d0_dout !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rd_after_wr: got valid=%b dout=%h, required 1 deadbeef", d0_vld, d0_dout);
    end
    drive(1'b0, 1'b1, 4'd0, 4'hF, 32'h0);
    n_checks++;
    if (d0_vld !== 1'b0 || d0_dout !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL dout_hold: got valid=%b dout=%h, required 0 deadbeef", d0_vld, d0_dout);
    end
    idle(2);
  endtask

  task automatic test_byte_lanes();
    drive(1'b1, 1'b0, 4'd3, 4'b1010, 32'h11223344);
    drive(1'b0, 1'b1, 4'd0, 4'hF, 32'h0);
    n_checks++;
    if (d0_vld !== 1'b1 || d0_dout !== 32'hDE22BE44) begin
      n_fail++;
      $display("FAIL lane_write_through: got valid=%b dout=%h, required 1 de22be44", d0_vld, d0_dout);
    end
    idle(2);
    drive(1'b1, 1'b1, 4'd3, 4'b0000, 32'h0);
    idle(3);
  endtask

  task automatic test_no_lane_write();
    drive(1'b1, 1'b0, 4'd3, 4'b1111, 32'hFFFFFFFF);
    drive(1'b1, 1'b1, 4'd3, 4'b0000, 32'h0);
    n_checks++;
    if (d0_vld !== 1'b1 || d0_dout !== 32'hDE22BE44) begin
      n_fail++;
      $display("FAIL no_lane_write: got valid=%b dout=%h, required 1 de22be44", d0_vld, d0_dout);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 8; a++) drive(1'b1, 1'b0, 4'(a), 4'b0000, 32'(a));
    idle(3);
    for (int j = 0; j <= 10; j++) begin
      if (j < 8) drive(1'b1, 1'b1, 4'(j), 4'hF, 32'h0);
      else       drive(1'b0, 1'b1, 4'd0, 4'hF, 32'h0);
      n_checks++;
      if (j < 2 || j == 10) begin
        if (d1_vld !== 1'b0) begin
          n_fail++;
          $display("FAIL p1_stream_gap_j%0d: got valid=%b, required 0", j, d1_vld);
        end
      end else if (d1_vld !== 1'b1 || d1_dout !== 32'(j - 2)) begin
        n_fail++;
        $display("FAIL p1_stream_j%0d: got valid=%b dout=%h, required 1 %h", j, d1_vld, d1_dout, 32'(j - 2));
      end
    end
    idle(2);
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 1'b0, 4'd9, 4'b0000, 32'hCAFEF00D);
    idle(3);
    drive(1'b1, 1'b1, 4'd9, 4'hF, 32'h0);
    drive(1'b1, 1'b1, 4'd3, 4'hF, 32'h0);
    @(posedge clk);
    #1;
    reset_b = 1'b0;
    req = 1'b0;
    q0.delete();
    q1.delete();
    clear_model();
    #1;
    n_checks++;
    if (d0_vld !== 1'b0 || d1_vld !== 1'b0 || d0_dout !== 32'h0 || d1_dout !== 32'h0 ||
        d0_busy !== 1'b1 || d1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_reset: got valid=%b/%b dout=%h/%h busy=%b/%b, required 0/0 0/0 1/1",
               d0_vld, d1_vld, d0_dout, d1_dout, d0_busy, d1_busy);
    end
    @(posedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    check_sweep("midflight");
    drive(1'b1, 1'b1, 4'd9, 4'hF, 32'h0);
    drive(1'b1, 1'b1, 4'd3, 4'hF, 32'h0);
    idle(4);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_no_lane_write();
    test_back_to_back();
    test_reset_midflight();
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL missing_responses: got %0d/%0d outstanding, required 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bytewr_pipe.md
Name: ram_bytewr_pipe

Overview:
- Parametrised single-port synchronous RAM with per-byte active-low lane selects and write-through readback.
- Adds an optional output pipeline stage, a valid-tagged response and a hardware clear sweep after reset.
- Serves as the general on-chip memory for CPU, stack and buffer use.
- Every accepted access, read or write, returns the post-access word on dout with a fixed latency.

Parameters:
- DW, 32: data width; must be a multiple of 8. NB = DW/8 byte lanes.
- AW, 13: address width. DEPTH = 2**AW words.
- PIPE, 0: 0 gives read latency 1; 1 adds an output register, giving latency 2.
- CLEAR_ON_RESET, 1: 1 zero-fills the whole array after reset; 0 skips the sweep.

Ports:
- clk  in  1  Rising-edge clock.
- reset_b  in  1  Asynchronous, active-low reset.
- req  in  1  Access request. Accepted on a clk edge when req=1 and busy=0.
- rnw  in  1  1 = read, 0 = write.
- address  in  AW  Word address.
- cs_b  in  NB  Active-low byte-lane selects. Bit i gates din[8i+7:8i] on writes. Ignored on reads.
- din  in  DW  Write data.
- dout  out  DW  Response word.
- dout_valid  out  1  High for one cycle per accepted request, LAT = 1+PIPE cycles after acceptance.
- busy  out  1  High while the clear sweep runs. Requests are ignored while busy=1.

Behaviour:
- Reset values: dout=0, dout_valid=0, all pipeline valid bits 0.
  - busy=1 if CLEAR_ON_RESET=1, else busy=0.
  - Array contents are not reset; the sweep handles zeroing.
- State machine, states CLEAR and RUN.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
  - In CLEAR, a clear counter starting at 0 writes an all-zero word to one address per cycle, all lanes.
  - After writing DEPTH-1, the state moves to RUN. busy falls on the same edge.
  - busy is high for exactly DEPTH cycles after reset_b deasserts.
- Acceptance: a request is accepted only in RUN with req=1. There is no backpressure; one request per cycle sustained.
- Read: dout = mem[address] as sampled at the acceptance edge.
- Write: on the acceptance edge, each lane i with cs_b[i]=0 takes din lane i. Lanes with cs_b[i]=1 keep their old value.
  - dout returns the merged post-write word: the new lane where written, the old lane otherwise.
- Write with cs_b all ones: no array change. dout returns the current word and dout_valid still pulses.
- Latency:
  - dout and dout_valid update LAT cycles after the acceptance edge (1 when PIPE=0, 2 when PIPE=1).
  - With no valid response, dout holds its last value.
- Back-to-back accesses: a read accepted the cycle after a write to the same address returns the written data. Ordering is strict program order.
- Address wrap: no wrap logic. address is always in range by width.
- Reset mid-operation: asserting reset_b low at any time immediately clears dout_valid, dout and all in-flight valid bits.
  - In-flight responses are discarded.
  - A partially completed write edge has either fully happened or not.
  - On release, the clear sweep restarts from address 0.
- req during CLEAR: silently dropped. No response, no array change.

Test Plan:
1. AW=4, CLEAR_ON_RESET=1: release reset_b and hold req=1 throughout -> busy=1 for exactly 16 cycles, no dout_valid during the sweep; a subsequent read of addr 5 returns 0x00000000.
2. PIPE=0: write addr 3, din=0xDEADBEEF, cs_b=4'b0000, then read addr 3 on the next cycle -> write response dout=0xDEADBEEF after 1 cycle; read response 0xDEADBEEF the following cycle; two consecutive dout_valid pulses.
3. Byte lanes: addr 3 holds 0xDEADBEEF; write din=0x11223344 with cs_b=4'b1010 -> write-through dout=0xDE22BE44; later read of addr 3 = 0xDE22BE44.
4. Write with cs_b=4'b1111 and din=0xFFFFFFFF to addr 3 -> dout_valid pulses, dout=0xDE22BE44, contents unchanged.
5. PIPE=1: stream 8 back-to-back reads of addrs 0..7 pre-loaded with value=addr -> dout_valid high for 8 consecutive cycles, starting 2 cycles after the first acceptance, dout sequence 0..7.
6. Assert reset_b low for 1 cycle with 2 reads in flight (PIPE=1) -> no dout_valid after reset; busy reasserts for DEPTH cycles; previously written data reads back 0 afterwards.
